// File: rtl/traffic_light_timed.sv
// Two-road highway/farm intersection controller: tick-timed phases, all-red clearance
// between roads, latched farm request and min/extend/max farm green.
package traffic_light_timed_pkg;

    typedef enum logic [2:0] {
        HGRE_FRED = 3'd0,
        HYEL_FRED = 3'd1,
        ARED_H    = 3'd2,
        HRED_FGRE = 3'd3,
        HRED_FYEL = 3'd4,
        ARED_F    = 3'd5
    } state_t;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

endpackage

module traffic_light_timed
    import traffic_light_timed_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int CNT_W      = 8,
    parameter int HWY_MIN_T  = 10,
    parameter int YEL_T      = 3,
    parameter int ALLRED_T   = 1,
    parameter int FARM_MIN_T = 5,
    parameter int FARM_MAX_T = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       C,
    output logic [2:0] light_highway,
    output logic [2:0] light_farm,
    output logic [2:0] state_o
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST      = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SAT       = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] HWY_MIN       = CNT_W'(HWY_MIN_T);
    localparam logic [CNT_W-1:0] YEL_LAST      = CNT_W'(YEL_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] FARM_MIN      = CNT_W'(FARM_MIN_T);
    localparam logic [CNT_W-1:0] FARM_MAX_LAST = CNT_W'(FARM_MAX_T - 1);

    logic [1:0]       sync_q;
    logic             c_sync;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [CNT_W-1:0] phase_cnt;
    logic             req;
    logic             phase_change;
    logic             req_window;
    state_t           state;
    state_t           state_nxt;

    function automatic logic [5:0] lamps_for(input state_t s);
        logic [5:0] lamps;
        case (s)
            HGRE_FRED: lamps = {LAMP_GREEN,  LAMP_RED};
            HYEL_FRED: lamps = {LAMP_YELLOW, LAMP_RED};
            HRED_FGRE: lamps = {LAMP_RED,    LAMP_GREEN};
            HRED_FYEL: lamps = {LAMP_RED,    LAMP_YELLOW};
            default:   lamps = {LAMP_RED,    LAMP_RED};
        endcase
        return lamps;
    endfunction

    // C is asynchronous to clk; two flops before any decision uses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, whatever the statement order.
            sync_q <= {sync_q[0], C};
        end
    end

    assign c_sync       = sync_q[1];
    assign tick         = (pre_cnt == PRE_LAST);
    assign phase_change = (state_nxt != state);
    assign req_window   = (state == HGRE_FRED) || (state == HYEL_FRED) || (state == ARED_H);
    assign state_o      = state;

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            HGRE_FRED:
                if ((phase_cnt >= HWY_MIN) && (req || c_sync)) state_nxt = HYEL_FRED;
            HYEL_FRED:
                if (tick && (phase_cnt == YEL_LAST)) state_nxt = ARED_H;
            ARED_H:
                if (tick && (phase_cnt == ALLRED_LAST)) state_nxt = HRED_FGRE;
            HRED_FGRE:
                // Max cap and gap-out share one target, so a coincidence is one transition.
                if ((tick && (phase_cnt == FARM_MAX_LAST)) ||
                    ((phase_cnt >= FARM_MIN) && !c_sync)) state_nxt = HRED_FYEL;
            HRED_FYEL:
                if (tick && (phase_cnt == YEL_LAST)) state_nxt = ARED_F;
            ARED_F:
                if (tick && (phase_cnt == ALLRED_LAST)) state_nxt = HGRE_FRED;
            default:
                state_nxt = ARED_H;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= HGRE_FRED;
            light_highway <= LAMP_GREEN;
            light_farm    <= LAMP_RED;
            pre_cnt       <= '0;
            phase_cnt     <= '0;
            req           <= 1'b0;
        end else begin
            state                       <= state_nxt;
            {light_highway, light_farm} <= lamps_for(state_nxt);

            // Timers restart on every phase change so each phase lasts exactly T ticks.
            if (phase_change) begin
                pre_cnt   <= '0;
                phase_cnt <= '0;
            end else begin
                pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
                if (tick && (phase_cnt != CNT_SAT)) phase_cnt <= phase_cnt + 1'b1;
            end

            // Clearing on farm-green entry wins over a same-edge set.
            if ((state_nxt == HRED_FGRE) && (state != HRED_FGRE)) begin
                req <= 1'b0;
            end else if (c_sync && req_window) begin
                req <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_timed.sv
// Self-checking bench for traffic_light_timed: directed phase-timing scenarios plus
// a randomized sensor run checked cycle by cycle against a cycle-count reference model.
module tb_traffic_light_timed;

    localparam int TD     = 4;
    localparam int HMIN   = 3;
    localparam int YEL    = 2;
    localparam int AR     = 1;
    localparam int FMIN   = 2;
    localparam int FMAX   = 5;

    // Edge numbers (from reset release) of each phase entry with C held high.
    localparam int E_HYEL  = HMIN * TD + 1;
    localparam int E_AREDH = E_HYEL + YEL * TD;
    localparam int E_FGRE  = E_AREDH + AR * TD;
    localparam int E_FYEL  = E_FGRE + FMAX * TD;
    localparam int E_AREDF = E_FYEL + YEL * TD;
    localparam int E_HGRE  = E_AREDF + AR * TD;

    logic       clk;
    logic       rst_n;
    logic       C;
    logic [2:0] light_highway;
    logic [2:0] light_farm;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_light_timed #(
        .TICK_DIV  (TD),
        .CNT_W     (8),
        .HWY_MIN_T (HMIN),
        .YEL_T     (YEL),
        .ALLRED_T  (AR),
        .FARM_MIN_T(FMIN),
        .FARM_MAX_T(FMAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .C            (C),
        .light_highway(light_highway),
        .light_farm   (light_farm),
        .state_o      (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] exp_hwy(input int ph);
        case (ph)
            0:       return 3'b001;
            1:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_farm(input int ph);
        case (ph)
            3:       return 3'b001;
            4:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // Reference model: tracks phase by cycles spent in it, not by prescaler/tick registers.
    int m_phase;
    int m_k;
    bit m_req;
    bit m_s1;
    bit m_s2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_k     = 0;
            m_req   = 0;
            m_s1    = 0;
            m_s2    = 0;
        end else begin
            automatic int ticks = m_k / TD;
            automatic int nxt   = m_phase;
            case (m_phase)
                0: if (ticks >= HMIN && (m_req || m_s2)) nxt = 1;
                1: if (m_k == YEL * TD - 1) nxt = 2;
                2: if (m_k == AR * TD - 1) nxt = 3;
                3: if (m_k == FMAX * TD - 1 || (ticks >= FMIN && !m_s2)) nxt = 4;
                4: if (m_k == YEL * TD - 1) nxt = 5;
                5: if (m_k == AR * TD - 1) nxt = 0;
                default: nxt = 2;
            endcase
            if (nxt == 3 && m_phase != 3) m_req = 0;
            else if (m_s2 && m_phase <= 2) m_req = 1;
            m_k     = (nxt != m_phase) ? 0 : m_k + 1;
            m_phase = nxt;
            m_s2    = m_s1;
            m_s1    = C;
        end
    end

    // Holds reset for a few cycles, releases on a falling edge: next rising edge is edge 1.
    task automatic do_reset(input logic c_val);
        rst_n = 1'b0;
        C     = c_val;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        C     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (state_o !== 3'd0 || light_highway !== 3'b001 || light_farm !== 3'b100) begin
                n_fail++;
                $display("FAIL reset_hold: state=%0d hwy=%b farm=%b want 0/001/100",
                         state_o, light_highway, light_farm);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n_checks++;
            if (state_o !== 3'd0 || light_highway !== 3'b001 || light_farm !== 3'b100) begin
                n_fail++;
                $display("FAIL idle_no_car cyc %0d: state=%0d hwy=%b farm=%b want 0/001/100",
                         i, state_o, light_highway, light_farm);
            end
        end
    endtask

    task automatic test_async_reset;
        int budget;
        do_reset(1'b1);
        budget = 0;
        while (state_o !== 3'd3 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        n_checks++;
        if (state_o !== 3'd3) begin
            n_fail++;
            $display("FAIL async_reset_reach_fgre: state=%0d want 3 within 100 cycles", state_o);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (state_o !== 3'd0 || light_highway !== 3'b001 || light_farm !== 3'b100) begin
            n_fail++;
            $display("FAIL async_reset_midcycle: state=%0d hwy=%b farm=%b want 0/001/100",
                     state_o, light_highway, light_farm);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_c_held;
        logic [2:0] exp;
        do_reset(1'b1);
        for (int e = 1; e <= E_HGRE + 3; e++) begin
            @(negedge clk);
            if      (e < E_HYEL)  exp = 3'd0;
            else if (e < E_AREDH) exp = 3'd1;
            else if (e < E_FGRE)  exp = 3'd2;
            else if (e < E_FYEL)  exp = 3'd3;
            else if (e < E_AREDF) exp = 3'd4;
            else if (e < E_HGRE)  exp = 3'd5;
            else                  exp = 3'd0;
            n_checks++;
            if (state_o !== exp || light_highway !== exp_hwy(int'(exp)) ||
                light_farm !== exp_farm(int'(exp))) begin
                n_fail++;
                $display("FAIL c_held edge %0d: state=%0d hwy=%b farm=%b want %0d/%b/%b",
                         e, state_o, light_highway, light_farm, exp,
                         exp_hwy(int'(exp)), exp_farm(int'(exp)));
            end
            n_checks++;
            if (light_highway !== 3'b100 && light_farm !== 3'b100) begin
                n_fail++;
                $display("FAIL c_held_two_go edge %0d: hwy=%b farm=%b", e, light_highway, light_farm);
            end
        end
    endtask

    task automatic test_pulse;
        logic [2:0] exp;
        do_reset(1'b0);
        @(negedge clk);
        C = 1'b1;
        @(negedge clk);
        C = 1'b0;
        for (int e = 3; e <= E_HYEL + 1; e++) begin
            @(negedge clk);
            exp = (e < E_HYEL) ? 3'd0 : 3'd1;
            n_checks++;
            if (state_o !== exp) begin
                n_fail++;
                $display("FAIL pulse_latched edge %0d: state=%0d want %0d", e, state_o, exp);
            end
        end
    endtask

    task automatic test_gap_out;
        logic [2:0] exp;
        do_reset(1'b1);
        repeat (E_FGRE) @(negedge clk);
        n_checks++;
        if (state_o !== 3'd3) begin
            n_fail++;
            $display("FAIL gap_entry: state=%0d want 3", state_o);
        end
        repeat (9) @(negedge clk);
        C = 1'b0;
        for (int d = 1; d <= 3; d++) begin
            @(negedge clk);
            exp = (d < 3) ? 3'd3 : 3'd4;
            n_checks++;
            if (state_o !== exp) begin
                n_fail++;
                $display("FAIL gap_out drop+%0d: state=%0d want %0d", d, state_o, exp);
            end
        end
    endtask

    task automatic test_no_rerequest;
        logic [2:0] exp;
        do_reset(1'b1);
        repeat (E_FYEL) @(negedge clk);
        n_checks++;
        if (state_o !== 3'd4) begin
            n_fail++;
            $display("FAIL norereq_fyel: state=%0d want 4", state_o);
        end
        for (int e = E_FYEL + 1; e <= E_HGRE - 2; e++) begin
            C = e[0];
            @(negedge clk);
        end
        C = 1'b0;
        for (int e = E_HGRE - 1; e <= E_HGRE + 24; e++) begin
            @(negedge clk);
            exp = (e < E_HGRE) ? 3'd5 : 3'd0;
            n_checks++;
            if (state_o !== exp) begin
                n_fail++;
                $display("FAIL norereq_hold edge %0d: state=%0d want %0d", e, state_o, exp);
            end
        end
        C = 1'b1;
        @(negedge clk);
        C = 1'b0;
        for (int d = 1; d <= 3; d++) begin
            exp = (d < 3) ? 3'd0 : 3'd1;
            n_checks++;
            if (state_o !== exp) begin
                n_fail++;
                $display("FAIL fresh_request +%0d: state=%0d want %0d", d, state_o, exp);
            end
            if (d < 3) @(negedge clk);
        end
    endtask

    task automatic test_random;
        int hold;
        do_reset(1'b0);
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n_checks++;
            if (state_o !== 3'(m_phase) || light_highway !== exp_hwy(m_phase) ||
                light_farm !== exp_farm(m_phase)) begin
                n_fail++;
                $display("FAIL random cyc %0d: state=%0d hwy=%b farm=%b want %0d/%b/%b",
                         i, state_o, light_highway, light_farm, m_phase,
                         exp_hwy(m_phase), exp_farm(m_phase));
            end
            n_checks++;
            if (light_highway !== 3'b100 && light_farm !== 3'b100) begin
                n_fail++;
                $display("FAIL random_two_go cyc %0d: hwy=%b farm=%b", i, light_highway, light_farm);
            end
            if (hold == 0) begin
                C    = 1'($urandom_range(0, 1));
                hold = $urandom_range(0, 30);
            end else begin
                hold--;
            end
            rst_n = ($urandom_range(0, 499) != 0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_illegal;
        do_reset(1'b0);
        repeat (5) @(negedge clk);
        force dut.state = traffic_light_timed_pkg::state_t'(3'd7);
        m_phase = 7;
        #1 release dut.state;
        n_checks++;
        if (state_o !== 3'd7) begin
            n_fail++;
            $display("FAIL illegal_forced: state=%0d want 7", state_o);
        end
        for (int d = 1; d <= AR * TD + 1; d++) begin
            @(negedge clk);
            if (d <= AR * TD) begin
                n_checks++;
                if (state_o !== 3'd2 || light_highway !== 3'b100 || light_farm !== 3'b100) begin
                    n_fail++;
                    $display("FAIL illegal_recover +%0d: state=%0d hwy=%b farm=%b want 2/100/100",
                             d, state_o, light_highway, light_farm);
                end
            end else begin
                n_checks++;
                if (state_o !== 3'd3 || light_farm !== 3'b001) begin
                    n_fail++;
                    $display("FAIL illegal_resume: state=%0d farm=%b want 3/001",
                             state_o, light_farm);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        C     = 1'b0;
        test_reset();
        test_async_reset();
        test_c_held();
        test_pulse();
        test_gap_out();
        test_no_rerequest();
        test_random();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
